// File: rtl/id_stage.sv
// MIPS instruction-decode stage: 32-entry register file with write-back
// bypass, R-type / immediate decode and the ID/EX pipeline register.
module id_stage #(
    parameter int NB_DATA  = 32,
    parameter int NB_OP    = 6,
    parameter int NB_ADDR  = 5,
    parameter int NB_INSTR = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NB_INSTR-1:0] i_instr,
    input  logic                i_valid,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_wb_en,
    input  logic [NB_ADDR-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0]  i_wb_data,
    output logic [NB_DATA-1:0]  o_data_1,
    output logic [NB_DATA-1:0]  o_data_2,
    output logic [NB_OP-1:0]    o_code,
    output logic [NB_ADDR-1:0]  o_rd,
    output logic                o_reg_write,
    output logic                o_valid,
    output logic                o_illegal
);

    localparam int NREG = 2 ** NB_ADDR;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [NB_OP-1:0] FN_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] FN_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] FN_OR  = NB_OP'(6'b100101);

    logic [5:0]         op;
    logic [NB_ADDR-1:0] rs;
    logic [NB_ADDR-1:0] rt;
    logic [NB_ADDR-1:0] rd;
    logic [NB_OP-1:0]   funct;
    logic [15:0]        imm;
    logic               unused_shamt;

    assign op           = i_instr[31:26];
    assign rs           = i_instr[25:21];
    assign rt           = i_instr[20:16];
    assign rd           = i_instr[15:11];
    assign funct        = i_instr[NB_OP-1:0];
    assign imm          = i_instr[15:0];
    assign unused_shamt = ^i_instr[10:6];

    logic [NB_DATA-1:0] gpr [NREG];
    logic               wb_live;

    assign wb_live = i_wb_en && (i_wb_addr != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
        end else if (wb_live) begin
            gpr[i_wb_addr] <= i_wb_data;
        end
    end

    // $0 is forced to zero on read; a same-cycle write-back wins over the array
    logic [NB_DATA-1:0] rs_val;
    logic [NB_DATA-1:0] rt_val;

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (wb_live && i_wb_addr == rs) rs_val = i_wb_data;
        else if (rs != '0)              rs_val = gpr[rs];
        if (wb_live && i_wb_addr == rt) rt_val = i_wb_data;
        else if (rt != '0)              rt_val = gpr[rt];
    end

    logic               is_r;
    logic               is_addi;
    logic               is_andi;
    logic               is_ori;
    logic               known;
    logic [NB_DATA-1:0] dec_d2;
    logic [NB_OP-1:0]   dec_code;
    logic [NB_ADDR-1:0] dec_rd;

    assign is_r    = (op == OP_R);
    assign is_addi = (op == OP_ADDI);
    assign is_andi = (op == OP_ANDI);
    assign is_ori  = (op == OP_ORI);
    assign known   = is_r || is_addi || is_andi || is_ori;

    always_comb begin
        dec_d2   = rt_val;
        dec_code = funct;
        dec_rd   = rd;
        unique case (1'b1)
            is_r: begin
                dec_d2   = rt_val;
                dec_code = funct;
                dec_rd   = rd;
            end
            is_addi: begin
                dec_d2   = {{(NB_DATA-16){imm[15]}}, imm};
                dec_code = FN_ADD;
                dec_rd   = rt;
            end
            is_andi: begin
                dec_d2   = {{(NB_DATA-16){1'b0}}, imm};
                dec_code = FN_AND;
                dec_rd   = rt;
            end
            is_ori: begin
                dec_d2   = {{(NB_DATA-16){1'b0}}, imm};
                dec_code = FN_OR;
                dec_rd   = rt;
            end
            default: ;
        endcase
    end

    // flush beats stall; stall holds everything but the illegal pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_1    <= '0;
            o_data_2    <= '0;
            o_code      <= '0;
            o_rd        <= '0;
            o_reg_write <= 1'b0;
            o_valid     <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (i_stall && !i_flush) begin
            o_illegal   <= 1'b0;
        end else if (i_flush || !i_valid || !known) begin
            o_data_1    <= '0;
            o_data_2    <= '0;
            o_code      <= '0;
            o_rd        <= '0;
            o_reg_write <= 1'b0;
            o_valid     <= 1'b0;
            o_illegal   <= !i_flush && i_valid && !known;
        end else begin
            o_data_1    <= rs_val;
            o_data_2    <= dec_d2;
            o_code      <= dec_code;
            o_rd        <= dec_rd;
            o_reg_write <= (dec_rd != '0);
            o_valid     <= 1'b1;
            o_illegal   <= 1'b0;
        end
    end

endmodule
